// File: rtl/routing_pkg.sv
// Shared routing-table definitions: memory geometry, table base addresses,
// neighbor table depth and the scan state encoding.
// SKIP_EMPTY_EN adds the RD_SC state used to read sinkIDCount per neighbor.
package routing_pkg;

   localparam int unsigned WORD_WIDTH    = 16;
   localparam int unsigned ADDR_WIDTH    = 11;
   localparam int unsigned MAX_NEIGHBORS = 16;

   // Word addresses; per-neighbor tables use a stride of 2 words.
   localparam int unsigned NEIGHBOR_COUNT_ADDR = 'h68A;
   localparam int unsigned BEST_NEIGHBOR_ADDR  = 'h68C;
   localparam int unsigned NEIGHBOR_ID_BASE    = 'h1A8;
   localparam int unsigned QVALUE_BASE         = 'h1C8;
   localparam int unsigned SINKID_COUNT_BASE   = 'h68E;

   typedef enum logic [2:0] {
      S_WAIT,
      S_IDLE,
      S_RD_CNT,
      S_RD_Q,
`ifdef SKIP_EMPTY_EN
      S_RD_SC,
`endif
      S_RD_ID,
      S_WR,
      S_DONE
   } state_t;

endpackage

// File: rtl/best_neighbor_select_min_tracker.sv
// min_tracker: registered running minimum of candidate qValues.
// Strict less-than keeps the earliest index on ties; the first offered
// candidate is always taken, so 16'hFFFF is a legal winner.
module min_tracker
   import routing_pkg::*;
#(
   parameter int unsigned Q_W   = WORD_WIDTH,
   parameter int unsigned IDX_W = 5
) (
   input  logic             clock,
   input  logic             nrst,
   input  logic             clear,
   input  logic             load,
   input  logic [Q_W-1:0]   cand_q,
   input  logic [IDX_W-1:0] cand_idx,
   output logic             hit,
   output logic [Q_W-1:0]   best_q,
   output logic [IDX_W-1:0] best_idx,
   output logic             best_valid
);

   assign hit = load && (!best_valid || (cand_q < best_q));

   // Best-so-far register; clear wins over load.
   always_ff @(posedge clock) begin
      if (!nrst || clear) begin
         best_q     <= '1;
         best_idx   <= '0;
         best_valid <= 1'b0;
      end else if (hit) begin
         best_q     <= cand_q;
         best_idx   <= cand_idx;
         best_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/best_neighbor_select.sv
// best_neighbor_select: scans qValue[0..neighborCount-1] for the minimum,
// fetches that neighbor's ID, writes it to bestNeighbor and presents it.
// Optional macro SKIP_EMPTY_EN: neighbors whose sinkIDCount is zero are
// excluded, costing one extra read (RD_SC) per neighbor.
module best_neighbor_select #(
   parameter int unsigned WORD_WIDTH    = routing_pkg::WORD_WIDTH,
   parameter int unsigned ADDR_WIDTH    = routing_pkg::ADDR_WIDTH,
   parameter int unsigned MAX_NEIGHBORS = routing_pkg::MAX_NEIGHBORS
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  wr_en,
   output logic [WORD_WIDTH-1:0] data_out,
   output logic [WORD_WIDTH-1:0] best_id,
   output logic [WORD_WIDTH-1:0] best_q,
   output logic                  best_valid,
   output logic                  done
);

   // Index must hold MAX_NEIGHBORS itself and is never narrower than 5 bits.
   localparam int unsigned IDX_BITS = $clog2(MAX_NEIGHBORS + 1);
   localparam int unsigned IDX_W    = (IDX_BITS < 5) ? 5 : IDX_BITS;
   localparam logic [IDX_W-1:0]      CNT_MAX   = IDX_W'(MAX_NEIGHBORS);
   localparam logic [WORD_WIDTH-1:0] CNT_MAX_W = WORD_WIDTH'(MAX_NEIGHBORS);

   typedef routing_pkg::state_t state_t;

   function automatic logic [ADDR_WIDTH-1:0] word_addr(input int unsigned base,
                                                       input logic [IDX_W-1:0] idx);
      return ADDR_WIDTH'(base + (32'(idx) << 1));
   endfunction

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] address_n;
   logic                  wr_en_n;
   logic [WORD_WIDTH-1:0] data_out_n;
   logic [WORD_WIDTH-1:0] best_id_n;
   logic                  done_n;
   logic [IDX_W-1:0]      i, i_n, i_inc;
   logic [IDX_W-1:0]      cnt, cnt_n;
   logic                  trk_clear, trk_load, trk_hit;
   logic [IDX_W-1:0]      best_idx;
   logic                  valid_after;
   logic [IDX_W-1:0]      idx_after;
`ifdef SKIP_EMPTY_EN
   logic                  sc_ok, sc_ok_n;
`endif

   min_tracker #(
      .Q_W   (WORD_WIDTH),
      .IDX_W (IDX_W)
   ) u_min (
      .clock      (clock),
      .nrst       (nrst),
      .clear      (trk_clear),
      .load       (trk_load),
      .cand_q     (data_in),
      .cand_idx   (i),
      .hit        (trk_hit),
      .best_q     (best_q),
      .best_idx   (best_idx),
      .best_valid (best_valid)
   );

   // The exit decision in RD_Q must see this cycle's candidate, so the
   // post-update valid/index are formed here instead of from the registers.
   assign i_inc       = i + IDX_W'(1);
   assign valid_after = best_valid | trk_hit;
   assign idx_after   = trk_hit ? i : best_idx;

   // Next-state and next-register values for the scan sequencer.
   always_comb begin
      state_n    = state;
      address_n  = address;
      wr_en_n    = 1'b0;
      data_out_n = data_out;
      best_id_n  = best_id;
      done_n     = done;
      i_n        = i;
      cnt_n      = cnt;
      trk_clear  = 1'b0;
      trk_load   = 1'b0;
`ifdef SKIP_EMPTY_EN
      sc_ok_n    = sc_ok;
`endif
      case (state)
         routing_pkg::S_WAIT: begin
            if (en) begin
               done_n    = 1'b0;
               trk_clear = 1'b1;
               i_n       = '0;
               state_n   = routing_pkg::S_IDLE;
            end
         end
         routing_pkg::S_IDLE: begin
            if (start) begin
               address_n = ADDR_WIDTH'(routing_pkg::NEIGHBOR_COUNT_ADDR);
               state_n   = routing_pkg::S_RD_CNT;
            end
         end
         routing_pkg::S_RD_CNT: begin
            if (data_in > CNT_MAX_W) begin
               cnt_n = CNT_MAX;
            end else begin
               cnt_n = IDX_W'(data_in);
            end
            if (data_in == '0) begin
               trk_clear = 1'b1;
               state_n   = routing_pkg::S_DONE;
            end else begin
`ifdef SKIP_EMPTY_EN
               address_n = word_addr(routing_pkg::SINKID_COUNT_BASE, i);
               state_n   = routing_pkg::S_RD_SC;
`else
               address_n = word_addr(routing_pkg::QVALUE_BASE, i);
               state_n   = routing_pkg::S_RD_Q;
`endif
            end
         end
`ifdef SKIP_EMPTY_EN
         routing_pkg::S_RD_SC: begin
            sc_ok_n   = (data_in != '0);
            address_n = word_addr(routing_pkg::QVALUE_BASE, i);
            state_n   = routing_pkg::S_RD_Q;
         end
`endif
         routing_pkg::S_RD_Q: begin
`ifdef SKIP_EMPTY_EN
            trk_load = sc_ok;
`else
            trk_load = 1'b1;
`endif
            i_n = i_inc;
            if (i_inc == cnt) begin
               if (valid_after) begin
                  address_n = word_addr(routing_pkg::NEIGHBOR_ID_BASE, idx_after);
                  state_n   = routing_pkg::S_RD_ID;
               end else begin
                  state_n = routing_pkg::S_DONE;
               end
            end else begin
`ifdef SKIP_EMPTY_EN
               address_n = word_addr(routing_pkg::SINKID_COUNT_BASE, i_inc);
               state_n   = routing_pkg::S_RD_SC;
`else
               address_n = word_addr(routing_pkg::QVALUE_BASE, i_inc);
`endif
            end
         end
         routing_pkg::S_RD_ID: begin
            best_id_n  = data_in;
            data_out_n = data_in;
            address_n  = ADDR_WIDTH'(routing_pkg::BEST_NEIGHBOR_ADDR);
            wr_en_n    = 1'b1;
            state_n    = routing_pkg::S_WR;
         end
         routing_pkg::S_WR: begin
            state_n = routing_pkg::S_DONE;
         end
         routing_pkg::S_DONE: begin
            done_n  = 1'b1;
            state_n = routing_pkg::S_WAIT;
         end
         default: begin
            state_n = routing_pkg::S_WAIT;
         end
      endcase
   end

   // State and registered outputs; reset drops any write in flight.
   always_ff @(posedge clock) begin
      if (!nrst) begin
         state    <= routing_pkg::S_WAIT;
         address  <= ADDR_WIDTH'(routing_pkg::NEIGHBOR_COUNT_ADDR);
         wr_en    <= 1'b0;
         data_out <= '0;
         best_id  <= '0;
         done     <= 1'b0;
         i        <= '0;
         cnt      <= '0;
`ifdef SKIP_EMPTY_EN
         sc_ok    <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         address  <= address_n;
         wr_en    <= wr_en_n;
         data_out <= data_out_n;
         best_id  <= best_id_n;
         done     <= done_n;
         i        <= i_n;
         cnt      <= cnt_n;
`ifdef SKIP_EMPTY_EN
         sc_ok    <= sc_ok_n;
`endif
      end
   end

endmodule

// File: tb/tb_best_neighbor_select.sv
// Bench for best_neighbor_select: directed cases plus randomized tables,
// checked against an argmin reference over a behavioural memory image.
module tb_best_neighbor_select;

   localparam int NC  = 'h68A;
   localparam int BN  = 'h68C;
   localparam int IDB = 'h1A8;
   localparam int QB  = 'h1C8;
   localparam int SCB = 'h68E;

   logic        clock = 1'b0;
   logic        nrst  = 1'b0;
   logic        en    = 1'b0;
   logic        start = 1'b0;
   logic [15:0] data_in;
   logic [10:0] address;
   logic        wr_en;
   logic [15:0] data_out;
   logic [15:0] best_id;
   logic [15:0] best_q;
   logic        best_valid;
   logic        done;

   logic [15:0] mem [2048];
   logic [31:0] wq [$];
   int          viol = 0;
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_id = 16'h0000;

   assign data_in = mem[address];

   always #5 clock = ~clock;

   best_neighbor_select #(
      .WORD_WIDTH    (16),
      .ADDR_WIDTH    (11),
      .MAX_NEIGHBORS (16)
   ) dut (
      .clock      (clock),
      .nrst       (nrst),
      .en         (en),
      .start      (start),
      .data_in    (data_in),
      .address    (address),
      .wr_en      (wr_en),
      .data_out   (data_out),
      .best_id    (best_id),
      .best_q     (best_q),
      .best_valid (best_valid),
      .done       (done)
   );

   always @(negedge clock) begin
      if (wr_en === 1'b1) wq.push_back({5'd0, address, data_out});
      if (address >= 11'h1E8 && address < 11'h1F8) viol++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Full scan from WAIT; pulse_at>0 raises start for one cycle mid-scan.
   task automatic run_scan(input string tag, input int pulse_at);
      int          raw, n, lat, lat_exp, midx;
      bit          seen, v;
      logic [15:0] minq, eid;
      logic [15:0] cq [$];
      int          ci [$];
      raw = int'(mem[NC]);
      n   = (raw > 16) ? 16 : raw;
      for (int k = 0; k < n; k++) begin
`ifdef SKIP_EMPTY_EN
         if (mem[SCB + 2*k] != 16'h0) begin
            cq.push_back(mem[QB + 2*k]);
            ci.push_back(k);
         end
`else
         cq.push_back(mem[QB + 2*k]);
         ci.push_back(k);
`endif
      end
      v    = (cq.size() > 0);
      minq = 16'hFFFF;
      foreach (cq[j]) if (cq[j] < minq) minq = cq[j];
      midx = 0;
      for (int j = cq.size() - 1; j >= 0; j--) if (cq[j] == minq) midx = ci[j];
      if (n == 0) lat_exp = 3;
`ifdef SKIP_EMPTY_EN
      else lat_exp = v ? 2*n + 5 : 2*n + 3;
`else
      else lat_exp = n + 5;
`endif
      eid = v ? mem[IDB + 2*midx] : exp_id;

      wq.delete();
      @(negedge clock); en = 1'b1;
      @(negedge clock); en = 1'b0; start = 1'b1;
      chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
      chk({tag, "_valid_clr"}, {31'd0, best_valid}, 32'd0);
      chk({tag, "_q_clr"}, {16'd0, best_q}, 32'hFFFF);
      lat  = 0;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         lat++;
         start = (lat == pulse_at);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, seen ? lat : 32'hFFFF_FFFF, lat_exp);
      chk({tag, "_valid"}, {31'd0, best_valid}, {31'd0, v});
      chk({tag, "_q"}, {16'd0, best_q}, {16'd0, (v ? minq : 16'hFFFF)});
      chk({tag, "_id"}, {16'd0, best_id}, {16'd0, eid});
      chk({tag, "_nwrites"}, wq.size(), v ? 1 : 0);
      if (v && wq.size() > 0) chk({tag, "_write"}, wq[0], {5'd0, 11'(BN), eid});
      exp_id = eid;
      repeat (2) @(negedge clock);
      chk({tag, "_done_held"}, {31'd0, done}, 32'd1);
      chk({tag, "_wr_idle"}, {31'd0, wr_en}, 32'd0);
   endtask

   task automatic set_table(input int cnt, input int k, input logic [15:0] q,
                            input logic [15:0] id, input logic [15:0] sc);
      mem[NC]        = 16'(cnt);
      mem[IDB + 2*k] = id;
      mem[QB + 2*k]  = q;
      mem[SCB + 2*k] = sc;
   endtask

   initial begin
      logic [15:0] t_q [4];
      logic [15:0] t_s [3];
      int          rc;

      for (int a = 0; a < 2048; a++) mem[a] = 16'($urandom);

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_address", {21'd0, address}, NC);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_data_out", {16'd0, data_out}, 32'd0);
      chk("rst_best_id", {16'd0, best_id}, 32'd0);
      chk("rst_best_q", {16'd0, best_q}, 32'hFFFF);
      chk("rst_best_valid", {31'd0, best_valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      nrst = 1'b1;

      // Basic 4-entry table with a tie at the minimum
      t_q[0] = 16'd7; t_q[1] = 16'd3; t_q[2] = 16'd9; t_q[3] = 16'd3;
      for (int k = 0; k < 4; k++) set_table(4, k, t_q[k], 16'hA0 + 16'(k), 16'd1);
      run_scan("basic", 0);
      chk("basic_id_const", {16'd0, best_id}, 32'hA1);
      chk("basic_q_const", {16'd0, best_q}, 32'd3);

      // Empty table, twice
      mem[NC] = 16'd0;
      run_scan("empty1", 0);
      run_scan("empty2", 0);

      // Count above table depth; a smaller q sits just beyond the clamp
      viol = 0;
      for (int k = 0; k < 16; k++)
         set_table(20, k, (k == 15) ? 16'd5 : 16'd100 + 16'(k), 16'hB000 + 16'(k), 16'd1);
      for (int k = 16; k < 20; k++) begin
         mem[QB + 2*k]  = 16'd1;
         mem[SCB + 2*k] = 16'd1;
      end
      run_scan("clamp", 4);
      chk("clamp_id_const", {16'd0, best_id}, 32'hB00F);
      chk("clamp_no_overread", viol, 0);

      // All entries at the maximum value
      for (int k = 0; k < 3; k++) set_table(3, k, 16'hFFFF, 16'hD0 + 16'(k), 16'd3);
      run_scan("allmax", 2);
      chk("allmax_id_const", {16'd0, best_id}, 32'hD0);

      // Empty-sink filtering table
      t_q[0] = 16'd1; t_q[1] = 16'd5; t_q[2] = 16'd2;
      t_s[0] = 16'd0; t_s[1] = 16'd2; t_s[2] = 16'd1;
      for (int k = 0; k < 3; k++) set_table(3, k, t_q[k], 16'hC0 + 16'(k), t_s[k]);
      run_scan("skip", 3);
`ifdef SKIP_EMPTY_EN
      chk("skip_id_const", {16'd0, best_id}, 32'hC2);
`else
      chk("skip_id_const", {16'd0, best_id}, 32'hC0);
`endif

      // Reset while scanning
      for (int k = 0; k < 8; k++) set_table(8, k, 16'd50 - 16'(k), 16'hE0 + 16'(k), 16'd1);
      @(negedge clock); en = 1'b1;
      @(negedge clock); en = 1'b0; start = 1'b1;
      @(negedge clock); start = 1'b0;
      repeat (3) @(negedge clock);
      nrst = 1'b0;
      @(negedge clock);
      nrst = 1'b1;
      chk("mid_rst_address", {21'd0, address}, NC);
      chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("mid_rst_data_out", {16'd0, data_out}, 32'd0);
      chk("mid_rst_best_id", {16'd0, best_id}, 32'd0);
      chk("mid_rst_best_q", {16'd0, best_q}, 32'hFFFF);
      chk("mid_rst_valid", {31'd0, best_valid}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      exp_id = 16'h0000;
      start = 1'b1;
      repeat (3) @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      chk("wait_ignores_start_addr", {21'd0, address}, NC);
      chk("wait_ignores_start_done", {31'd0, done}, 32'd0);
      run_scan("after_rst", 0);

      // Randomized tables
      for (int r = 0; r < 15; r++) begin
         rc = int'($urandom_range(0, 20));
         for (int k = 0; k < 16; k++)
            set_table(rc, k,
                      (r % 2 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom),
                      16'($urandom),
                      16'($urandom_range(0, 3)));
         for (int k = 16; k < 20; k++) mem[QB + 2*k] = 16'd0;
         run_scan($sformatf("rand%0d", r), (r % 3 == 0) ? 3 : 0);
      end
      chk("final_no_overread", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/best_neighbor_select.md
Name: best_neighbor_select

Overview:
- Read-side consumer of the neighbor tables that the sink-list fixer updates in shared 2K x 16 memory.
- On start, scans qValue[0..neighborCount-1] for the minimum and looks up that neighbor's ID.
- Writes the ID back to the bestNeighbor word and presents ID and qValue on ports.
- Same memory master interface and start/en/done handshake as the other routing-table blocks; it sits behind the top-level sequencer.

Parameters:
- WORD_WIDTH, 16, memory word width.
- ADDR_WIDTH, 11, memory address width.
- MAX_NEIGHBORS, 16, table depth. neighborCount values above this are clamped to it.

Ports:
- clock  in  1  system clock
- nrst  in  1  synchronous, active-low reset
- en  in  1  re-arm from WAIT state
- start  in  1  begin scan (sampled in IDLE only)
- data_in  in  WORD_WIDTH  memory read data
- address  out  ADDR_WIDTH  memory address (registered)
- wr_en  out  1  memory write strobe (registered)
- data_out  out  WORD_WIDTH  memory write data (registered)
- best_id  out  WORD_WIDTH  selected neighbor ID
- best_q  out  WORD_WIDTH  selected qValue
- best_valid  out  1  a neighbor was selected
- done  out  1  scan complete; held until en

Behaviour:
Interface and reset
- Reset: nrst is synchronous, active-low, on clock.
  - Reset values: state=WAIT, done=0, wr_en=0, address=0x68A, data_out=0, best_id=0, best_q=16'hFFFF, best_valid=0, i=0.
- Reset in any state aborts the scan immediately. A write in flight is dropped, because wr_en is cleared on the same edge.
- Memory timing: address is registered at edge N; data_in is sampled at edge N+1.

Memory map (word addresses, stride 2)
- neighborCount 0x68A
- bestNeighbor 0x68C (written)
- neighborID 0x1A8+2*i
- qValue 0x1C8+2*i
- sinkIDCount 0x68E+2*i

State machine
- WAIT:
  - en=1: done=0, wr_en=0, best_valid=0, best_q=FFFF, i=0 -> IDLE.
  - Otherwise stay in WAIT.
- IDLE:
  - start=1: address=0x68A -> RD_CNT.
  - start is ignored in every other state.
- RD_CNT: cnt=min(data_in, MAX_NEIGHBORS).
  - cnt==0 -> DONE, with best_valid=0.
  - Otherwise address=0x1C8 -> RD_Q.
- RD_Q: q=data_in. Candidate rule: update (best_q, best_idx) and set best_valid=1 when best_valid==0 or q<best_q.
  - Comparison is strict unsigned, so on ties the lowest index wins.
  - q==FFFF is a legal candidate.
  - Then i=i+1.
    - i==cnt and best_valid: address=0x1A8+2*best_idx -> RD_ID.
    - i==cnt and !best_valid: -> DONE.
    - Otherwise: address=0x1C8+2*i, stay in RD_Q.
- RD_ID: best_id=data_in, data_out=data_in, address=0x68C, wr_en=1 -> WR.
- WR: wr_en=0 -> DONE. wr_en is high for exactly 1 cycle.
- DONE: done=1 -> WAIT.
- Undefined state -> WAIT.

Latency and width rules
- Latency from start to done=1 is cnt+5 cycles when a neighbor is selected, and 3 cycles when cnt==0.
- Index arithmetic is at least 5 bits wide, so i==16 does not wrap.
- Address arithmetic is truncated to ADDR_WIDTH.

Optional Feature:
- Macro: SKIP_EMPTY_EN.
- Defined: between RD_Q samples, insert state RD_SC, which reads sinkIDCount 0x68E+2*i. A neighbor with sinkIDCount==0 is not a candidate. Latency becomes 2*cnt+5.
- Undefined: all neighbors are candidates and RD_SC does not exist.

Decomposition:
- Shared package routing_pkg holds:
  - WORD_WIDTH and ADDR_WIDTH.
  - All base addresses: NEIGHBOR_COUNT_ADDR, BEST_NEIGHBOR_ADDR, NEIGHBOR_ID_BASE, QVALUE_BASE, SINKID_COUNT_BASE.
  - MAX_NEIGHBORS.
  - The state enum.
- One sub-module is natural: min_tracker, which holds the registered best_q/best_idx/best_valid compare with strict less-than and clear/load inputs.

Test Plan:
- cnt=4, q={7,3,9,3}, ID={0xA0,0xA1,0xA2,0xA3} -> best_id=0xA1, best_q=3, one write of 0xA1 to 0x68C, done 9 cycles after start.
- cnt=0 -> no write, best_valid=0, done 3 cycles after start; en then start repeats identically.
- cnt=20, with the minimum at index 15 and an extra entry beyond it -> clamped to 16; no read above 0x1C8+30; index 15 is selected.
- All q=FFFF, cnt=3 -> best_idx=0, best_valid=1, best_q=FFFF.
- nrst low during RD_Q, then high -> all outputs at reset values, state WAIT; start without en is ignored.
- SKIP_EMPTY_EN defined: cnt=3, q={1,5,2}, sinkIDCount={0,2,1} -> best_id=ID[2], best_q=2; start pulsed while busy has no effect.
